// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and the mapper / DAC stage.
// The generator owns the timing outputs; the consumer supplies the pixel qualifier.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic       hs_d;
  logic       vs_d;
  logic       blank_d;

  modport master (
    input  pix_en,
    output DrawX, DrawY, blank, hs, vs, frame_start, hs_d, vs_d, blank_d
  );

  modport slave (
    output pix_en,
    input  DrawX, DrawY, blank, hs, vs, frame_start, hs_d, vs_d, blank_d
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counter with registered sync/blank decode, plus a pix_en-gated
// delay line that re-aligns sync/blank with the mapper's registered RGB.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACT  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vis_q, vis_d;
  logic       fs_q, fs_d;
  logic [2:0] dly_q [PIPE_DELAY];

  // Decode looks at the next counter value so the registered flags land with DrawX/DrawY.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (vga.pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    vis_d   = (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d = !((h_d >= HS_BEG) && (h_d <= HS_END));
    vsync_d = !((v_d >= VS_BEG) && (v_d <= VS_END));
    fs_d    = (h_d == '0) && (v_d == '0);
  end

  // Delay stages reset to the idle sync pattern {hs=1, vs=1, blank=0}.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      vis_q   <= 1'b0;
      fs_q    <= 1'b0;
      for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= 3'b110;
    end else if (vga.pix_en) begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vis_q    <= vis_d;
      fs_q     <= fs_d;
      dly_q[0] <= {hsync_q, vsync_q, vis_q};
      for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign vga.DrawX       = h_q;
  assign vga.DrawY       = v_q;
  assign vga.blank       = vis_q;
  assign vga.hs          = hsync_q;
  assign vga.vs          = vsync_q;
  assign vga.frame_start = fs_q;
  assign {vga.hs_d, vga.vs_d, vga.blank_d} = dly_q[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size instance for line-level timing and a shrunken-raster
// instance so frame wrap, vsync and mid-frame reset fit in a short run.
module tb_vga_timing_gen;
  localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;   // 25
  localparam int SVT = SVV + SVF + SVS + SVB;   // 19
  localparam int SPD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if vf ();
  vga_timing_gen_if vsm ();

  vga_timing_gen u_full (
    .vga_clk (clk),
    .reset_n (rst_n),
    .vga     (vf)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .PIPE_DELAY(SPD)
  ) u_small (
    .vga_clk (clk),
    .reset_n (rst_n),
    .vga     (vsm)
  );

  // reference model state: {fs, hs, vs, blank} plus delay history of {hs, vs, blank}
  int         fx, fy, sx, sy;
  logic [3:0] fcur, scur;
  logic [2:0] fdl [8];
  logic [2:0] sdl [8];
  logic [26:0] e, o;

  function automatic logic [3:0] dec(int x, int y, int hv, int hf, int hsw,
                                     int vv, int vf_, int vsw);
    logic fs, hs, vs, bl;
    fs = (x == 0) && (y == 0);
    hs = !((x >= hv + hf) && (x <= hv + hf + hsw - 1));
    vs = !((y >= vv + vf_) && (y <= vv + vf_ + vsw - 1));
    bl = (x < hv) && (y < vv);
    return {fs, hs, vs, bl};
  endfunction

  task automatic model_reset_full();
    fx = 0; fy = 0; fcur = 4'b0110;
    for (int i = 0; i < 8; i++) fdl[i] = 3'b110;
  endtask

  task automatic model_reset_small();
    sx = 0; sy = 0; scur = 4'b0110;
    for (int i = 0; i < 8; i++) sdl[i] = 3'b110;
  endtask

  task automatic step_full();
    for (int i = 7; i > 0; i--) fdl[i] = fdl[i-1];
    fdl[0] = fcur[2:0];
    if (fx == 799) begin
      fx = 0;
      fy = (fy == 524) ? 0 : fy + 1;
    end else fx = fx + 1;
    fcur = dec(fx, fy, 640, 16, 96, 480, 10, 2);
  endtask

  task automatic step_small();
    for (int i = 7; i > 0; i--) sdl[i] = sdl[i-1];
    sdl[0] = scur[2:0];
    if (sx == SHT - 1) begin
      sx = 0;
      sy = (sy == SVT - 1) ? 0 : sy + 1;
    end else sx = sx + 1;
    scur = dec(sx, sy, SHV, SHF, SHS, SVV, SVF, SVS);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vf.pix_en = 1'b0;
    vsm.pix_en = 1'b0;
    model_reset_full();
    model_reset_small();
    repeat (3) @(negedge clk);
    checks++;
    if (vf.DrawX !== 10'd0 || vf.DrawY !== 10'd0) begin
      errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", vf.DrawX, vf.DrawY);
    end
    checks++;
    if ({vf.hs, vf.vs, vf.hs_d, vf.vs_d} !== 4'b1111) begin
      errors++; $display("FAIL reset_sync: got %b want 1111", {vf.hs, vf.vs, vf.hs_d, vf.vs_d});
    end
    checks++;
    if ({vf.blank, vf.blank_d, vf.frame_start} !== 3'b000) begin
      errors++; $display("FAIL reset_blank: got %b want 000", {vf.blank, vf.blank_d, vf.frame_start});
    end
    o = {vsm.DrawX, vsm.DrawY, vsm.frame_start, vsm.hs, vsm.vs, vsm.blank, vsm.hs_d, vsm.vs_d, vsm.blank_d};
    checks++;
    if (o !== {20'd0, 4'b0110, 3'b110}) begin
      errors++; $display("FAIL reset_small: got %h want %h", o, {20'd0, 4'b0110, 3'b110});
    end
  endtask

  task automatic test_line();
    int hs_low = 0, blank_hi = 0;
    vf.pix_en = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      step_full();
      e = {10'(fx), 10'(fy), fcur, fdl[1]};
      o = {vf.DrawX, vf.DrawY, vf.frame_start, vf.hs, vf.vs, vf.blank, vf.hs_d, vf.vs_d, vf.blank_d};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL line_cyc%0d: got %h want %h", k, o, e);
      end
      if (!vf.hs) hs_low++;
      if (vf.blank) blank_hi++;
    end
    checks++;
    if (hs_low !== 96) begin
      errors++; $display("FAIL hs_width: got %0d want 96", hs_low);
    end
    checks++;
    if (blank_hi !== 640) begin
      errors++; $display("FAIL blank_count: got %0d want 640", blank_hi);
    end
    checks++;
    if (vf.DrawX !== 10'd0 || vf.DrawY !== 10'd1) begin
      errors++; $display("FAIL line_wrap: got %0d,%0d want 0,1", vf.DrawX, vf.DrawY);
    end
  endtask

  task automatic test_pix_en_toggle();
    for (int k = 0; k < 40; k++) begin
      vf.pix_en = (k % 2 == 0);
      @(negedge clk);
      if (k % 2 == 0) step_full();
      e = {10'(fx), 10'(fy), fcur, fdl[1]};
      o = {vf.DrawX, vf.DrawY, vf.frame_start, vf.hs, vf.vs, vf.blank, vf.hs_d, vf.vs_d, vf.blank_d};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL toggle_cyc%0d: got %h want %h", k, o, e);
      end
    end
    vf.pix_en = 1'b0;
    checks++;
    if (vf.DrawX !== 10'd20 || vf.DrawY !== 10'd1) begin
      errors++; $display("FAIL toggle_pos: got %0d,%0d want 20,1", vf.DrawX, vf.DrawY);
    end
  endtask

  task automatic test_frame();
    int vs_low = 0, fs_cnt = 0, first_fs = -1, last_fs = -1, bad_blank = 0;
    vsm.pix_en = 1'b1;
    for (int k = 0; k < 2 * SHT * SVT; k++) begin
      @(negedge clk);
      step_small();
      e = {10'(sx), 10'(sy), scur, sdl[SPD-1]};
      o = {vsm.DrawX, vsm.DrawY, vsm.frame_start, vsm.hs, vsm.vs, vsm.blank, vsm.hs_d, vsm.vs_d, vsm.blank_d};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL frame_cyc%0d: got %h want %h", k, o, e);
      end
      if (!vsm.vs) vs_low++;
      if (vsm.frame_start) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = k;
        last_fs = k;
      end
      if (vsm.blank && sy >= SVV) bad_blank++;
      if (sx == SHV - 1 && sy == SVV - 1) begin
        checks++;
        if (vsm.blank !== 1'b1) begin
          errors++; $display("FAIL last_visible: got %b want 1", vsm.blank);
        end
      end
      if ((sx == SHV && sy == SVV - 1) || (sx == 0 && sy == SVV)) begin
        checks++;
        if (vsm.blank !== 1'b0) begin
          errors++; $display("FAIL edge_blank(%0d,%0d): got %b want 0", sx, sy, vsm.blank);
        end
      end
    end
    checks++;
    if (vs_low !== 2 * SVS * SHT) begin
      errors++; $display("FAIL vs_width: got %0d want %0d", vs_low, 2 * SVS * SHT);
    end
    checks++;
    if (fs_cnt !== 2 || first_fs !== 474 || last_fs !== 949) begin
      errors++; $display("FAIL frame_start: got n=%0d at %0d,%0d want n=2 at 474,949", fs_cnt, first_fs, last_fs);
    end
    checks++;
    if (bad_blank !== 0) begin
      errors++; $display("FAIL vblank: got %0d visible pixels in blanking lines want 0", bad_blank);
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    while (!(sx == 10 && sy == 7) && budget < 600) begin
      @(negedge clk);
      step_small();
      budget++;
    end
    checks++;
    if (budget >= 600) begin
      errors++; $display("FAIL mid_reach: got timeout at %0d,%0d want 10,7", sx, sy);
    end
    checks++;
    if (vsm.DrawX !== 10'd10 || vsm.DrawY !== 10'd7) begin
      errors++; $display("FAIL mid_pos: got %0d,%0d want 10,7", vsm.DrawX, vsm.DrawY);
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = {vsm.DrawX, vsm.DrawY, vsm.frame_start, vsm.hs, vsm.vs, vsm.blank, vsm.hs_d, vsm.vs_d, vsm.blank_d};
    checks++;
    if (o !== {20'd0, 4'b0110, 3'b110}) begin
      errors++; $display("FAIL async_reset: got %h want %h", o, {20'd0, 4'b0110, 3'b110});
    end
    checks++;
    if (vf.DrawX !== 10'd0 || vf.DrawY !== 10'd0) begin
      errors++; $display("FAIL async_reset_full: got %0d,%0d want 0,0", vf.DrawX, vf.DrawY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset_small();
    @(negedge clk);
    step_small();
    e = {10'(sx), 10'(sy), scur, sdl[SPD-1]};
    o = {vsm.DrawX, vsm.DrawY, vsm.frame_start, vsm.hs, vsm.vs, vsm.blank, vsm.hs_d, vsm.vs_d, vsm.blank_d};
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL restart_vec: got %h want %h", o, e);
    end
    checks++;
    if (vsm.DrawX !== 10'd1 || vsm.blank !== 1'b1) begin
      errors++; $display("FAIL restart: got x=%0d blank=%b want x=1 blank=1", vsm.DrawX, vsm.blank);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_pix_en_toggle();
    test_frame();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
